// File: rtl/mem_stage_hs.sv
// Memory pipeline stage: bus handshake FSM (IDLE/WAIT), load/store lane steering, wait timeout.
// Optional MEM_MISALIGN_TRAP_EN: misaligned half/word/double accesses raise memErr_MEM instead of being aligned.
module mem_stage_hs #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned SIDE_W  = 96,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_EXE,
  input  logic              regFileWe_EXE,
  input  logic [2:0]        RFWDSrcMuxSel_EXE,
  input  logic              memRe_EXE,
  input  logic              memWe_EXE,
  input  logic [2:0]        funct3_EXE,
  input  logic [XLEN-1:0]   aluResult_EXE,
  input  logic [XLEN-1:0]   RFData2_EXE,
  input  logic [SIDE_W-1:0] side_EXE,
  input  logic              flush,
  output logic              stall_out,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [XLEN/8-1:0] bus_be,
  input  logic              bus_ready,
  input  logic [XLEN-1:0]   bus_rdata,
  output logic              valid_MEM,
  output logic              regFileWe_MEM,
  output logic              memErr_MEM,
  output logic [2:0]        RFWDSrcMuxSel_MEM,
  output logic [XLEN-1:0]   aluResult_MEM,
  output logic [XLEN-1:0]   busRData_MEM,
  output logic [SIDE_W-1:0] side_MEM
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(NB);

  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_n;

  logic [15:0]       cnt;
  logic              w_we, w_rfwe;
  logic [2:0]        w_sel, w_f3;
  logic [XLEN-1:0]   w_alu, w_rs2;
  logic [SIDE_W-1:0] w_side;

  logic              c_we, c_rfwe;
  logic [2:0]        c_sel, c_f3;
  logic [XLEN-1:0]   c_alu, c_rs2;
  logic [SIDE_W-1:0] c_side;

  logic [OFF_W-1:0]  off, half_off, word_off, lane_off;
  logic [XLEN-1:0]   sh, load_data, st_wdata;
  logic [NB-1:0]     st_be;
  logic              acc_ok, is_acc, mis, cap;
  logic              o_load, o_valid, o_err, o_rfwe;
  logic [XLEN-1:0]   o_rdata;

  // In WAIT the bus and writeback fields come from the captured copy, so upstream may change freely.
  always_comb begin
    if (state == WAIT) begin
      c_we = w_we;  c_rfwe = w_rfwe; c_sel = w_sel; c_f3 = w_f3;
      c_alu = w_alu; c_rs2 = w_rs2;  c_side = w_side;
    end else begin
      c_we = memWe_EXE;     c_rfwe = regFileWe_EXE; c_sel = RFWDSrcMuxSel_EXE;
      c_f3 = funct3_EXE;    c_alu = aluResult_EXE;  c_rs2 = RFData2_EXE;
      c_side = side_EXE;
    end
  end

  assign off      = c_alu[OFF_W-1:0];
  assign half_off = off & ~OFF_W'(1);
  assign word_off = off & ~OFF_W'(3);

  always_comb begin
    case (c_f3[1:0])
      2'b00: begin st_wdata = {NB{c_rs2[7:0]}};           st_be = NB'(1)  << off;      lane_off = off;      end
      2'b01: begin st_wdata = {(NB/2){c_rs2[15:0]}};      st_be = NB'(3)  << half_off; lane_off = half_off; end
      2'b10: begin st_wdata = {(XLEN/32){c_rs2[31:0]}};   st_be = NB'(15) << word_off; lane_off = word_off; end
      default: begin st_wdata = c_rs2;                    st_be = '1;                  lane_off = '0;       end
    endcase
  end

  assign sh = bus_rdata >> {lane_off, 3'b000};

  always_comb begin
    case (c_f3[1:0])
      2'b00:   load_data = c_f3[2] ? XLEN'(sh[7:0])  : XLEN'($signed(sh[7:0]));
      2'b01:   load_data = c_f3[2] ? XLEN'(sh[15:0]) : XLEN'($signed(sh[15:0]));
      2'b10:   load_data = c_f3[2] ? XLEN'(sh[31:0]) : XLEN'($signed(sh[31:0]));
      default: load_data = sh;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_comb begin
    case (funct3_EXE[1:0])
      2'b01:   mis = aluResult_EXE[0];
      2'b10:   mis = |aluResult_EXE[1:0];
      2'b11:   mis = (XLEN == 64) && (|aluResult_EXE[2:0]);
      default: mis = 1'b0;
    endcase
  end
`else
  assign mis = 1'b0;
`endif

  assign is_acc    = memRe_EXE | memWe_EXE;
  assign acc_ok    = reset_n & valid_EXE & ~flush & (state == IDLE);
  assign stall_out = (state == WAIT);

  assign bus_we    = bus_req & c_we;
  assign bus_be    = bus_req ? st_be : '0;
  assign bus_addr  = ADDR_W'(c_alu);
  assign bus_wdata = st_wdata;

  always_comb begin
    state_n = state;
    bus_req = 1'b0;
    cap     = 1'b0;
    o_load  = 1'b0;
    o_valid = 1'b0;
    o_err   = 1'b0;
    o_rfwe  = c_rfwe;
    o_rdata = '0;
    case (state)
      IDLE: begin
        if (acc_ok) begin
          if (!is_acc) begin
            o_load = 1'b1; o_valid = 1'b1;
          end else if (mis) begin
            o_load = 1'b1; o_valid = 1'b1; o_err = 1'b1; o_rfwe = 1'b0;
          end else begin
            bus_req = 1'b1;
            if (bus_ready) begin
              o_load = 1'b1; o_valid = 1'b1;
              o_rdata = c_we ? '0 : load_data;
            end else begin
              cap = 1'b1;
              state_n = WAIT;
            end
          end
        end
      end
      WAIT: begin
        bus_req = 1'b1;
        if (bus_ready) begin
          o_load = 1'b1; o_valid = 1'b1;
          o_rdata = c_we ? '0 : load_data;
          state_n = IDLE;
        end else if (cnt == 16'(TIMEOUT - 1)) begin
          o_load = 1'b1; o_valid = 1'b1; o_err = 1'b1; o_rfwe = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= (state == WAIT) ? cnt + 16'd1 : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_we <= 1'b0; w_rfwe <= 1'b0; w_sel <= '0; w_f3 <= '0;
      w_alu <= '0;  w_rs2 <= '0;    w_side <= '0;
    end else if (cap) begin
      w_we <= memWe_EXE;  w_rfwe <= regFileWe_EXE; w_sel <= RFWDSrcMuxSel_EXE;
      w_f3 <= funct3_EXE; w_alu <= aluResult_EXE;  w_rs2 <= RFData2_EXE;
      w_side <= side_EXE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_MEM <= 1'b0; regFileWe_MEM <= 1'b0; memErr_MEM <= 1'b0;
      RFWDSrcMuxSel_MEM <= '0; aluResult_MEM <= '0; busRData_MEM <= '0; side_MEM <= '0;
    end else begin
      valid_MEM <= o_valid;
      if (o_load) begin
        regFileWe_MEM     <= o_rfwe;
        memErr_MEM        <= o_err;
        RFWDSrcMuxSel_MEM <= c_sel;
        aluResult_MEM     <= c_alu;
        busRData_MEM      <= o_rdata;
        side_MEM          <= c_side;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs (XLEN=32, TIMEOUT=4): vector table plus wait/timeout/reset sequences.
module tb_mem_stage_hs;

  logic        clk, reset_n;
  logic        valid_EXE, regFileWe_EXE, memRe_EXE, memWe_EXE, flush;
  logic [2:0]  RFWDSrcMuxSel_EXE, funct3_EXE;
  logic [31:0] aluResult_EXE, RFData2_EXE, bus_rdata;
  logic [95:0] side_EXE;
  logic        stall_out, bus_req, bus_we, bus_ready;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        valid_MEM, regFileWe_MEM, memErr_MEM;
  logic [2:0]  RFWDSrcMuxSel_MEM;
  logic [31:0] aluResult_MEM, busRData_MEM;
  logic [95:0] side_MEM;

  int checks = 0;
  int errors = 0;

  mem_stage_hs #(.XLEN(32), .ADDR_W(32), .SIDE_W(96), .TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .valid_EXE(valid_EXE), .regFileWe_EXE(regFileWe_EXE), .RFWDSrcMuxSel_EXE(RFWDSrcMuxSel_EXE),
    .memRe_EXE(memRe_EXE), .memWe_EXE(memWe_EXE), .funct3_EXE(funct3_EXE),
    .aluResult_EXE(aluResult_EXE), .RFData2_EXE(RFData2_EXE), .side_EXE(side_EXE),
    .flush(flush), .stall_out(stall_out),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .valid_MEM(valid_MEM), .regFileWe_MEM(regFileWe_MEM), .memErr_MEM(memErr_MEM),
    .RFWDSrcMuxSel_MEM(RFWDSrcMuxSel_MEM), .aluResult_MEM(aluResult_MEM),
    .busRData_MEM(busRData_MEM), .side_MEM(side_MEM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        v, fl, re, we, rfwe;
    logic [2:0]  f3, sel;
    logic [31:0] alu, rs2, rdata;
    logic        e_req, e_we;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_valid, e_rfwe, e_err;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(string n, logic v, logic fl, logic re, logic we, logic rfwe,
                              logic [2:0] f3, logic [2:0] sel, logic [31:0] alu, logic [31:0] rs2,
                              logic [31:0] rdata, logic e_req, logic e_we, logic [3:0] e_be,
                              logic [31:0] e_wdata, logic e_valid, logic e_rfwe, logic e_err,
                              logic [31:0] e_rdata);
    vec_t r;
    r.name = n; r.v = v; r.fl = fl; r.re = re; r.we = we; r.rfwe = rfwe;
    r.f3 = f3; r.sel = sel; r.alu = alu; r.rs2 = rs2; r.rdata = rdata;
    r.e_req = e_req; r.e_we = e_we; r.e_be = e_be; r.e_wdata = e_wdata;
    r.e_valid = e_valid; r.e_rfwe = e_rfwe; r.e_err = e_err; r.e_rdata = e_rdata;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    valid_EXE = 1'b0; regFileWe_EXE = 1'b0; RFWDSrcMuxSel_EXE = '0;
    memRe_EXE = 1'b0; memWe_EXE = 1'b0; funct3_EXE = '0;
    aluResult_EXE = '0; RFData2_EXE = '0; side_EXE = '0;
    flush = 1'b0; bus_ready = 1'b0; bus_rdata = '0;
  endtask

  vec_t        v;
  logic [95:0] exp_side;
  int          stalls;

  initial begin
    reset_n = 1'b0;
    idle_inputs();

    //            name      v  fl re we rf f3      sel     alu           rs2           rdata         req we be       wdata         val rf er rdata
    vt.push_back(mk("nonacc", 1, 0, 0, 0, 1, 3'b000, 3'b010, 32'h12345678, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        1, 1, 0, 32'h0));
    vt.push_back(mk("sb",     1, 0, 0, 1, 0, 3'b000, 3'b000, 32'h103,      32'h123456A5, 32'h0,        1, 1, 4'b1000, 32'hA5A5A5A5, 1, 0, 0, 32'h0));
    vt.push_back(mk("sh",     1, 0, 0, 1, 0, 3'b001, 3'b000, 32'h102,      32'h0000BEEF, 32'h0,        1, 1, 4'b1100, 32'hBEEFBEEF, 1, 0, 0, 32'h0));
    vt.push_back(mk("sw",     1, 0, 0, 1, 0, 3'b010, 3'b000, 32'h100,      32'hCAFEF00D, 32'h0,        1, 1, 4'b1111, 32'hCAFEF00D, 1, 0, 0, 32'h0));
    vt.push_back(mk("lb",     1, 0, 1, 0, 1, 3'b000, 3'b001, 32'h101,      32'h0,        32'h00007F00, 1, 0, 4'b0000, 32'h0,        1, 1, 0, 32'h0000007F));
    vt.push_back(mk("lbu",    1, 0, 1, 0, 1, 3'b100, 3'b001, 32'h103,      32'h0,        32'h80000000, 1, 0, 4'b0000, 32'h0,        1, 1, 0, 32'h00000080));
    vt.push_back(mk("lh",     1, 0, 1, 0, 1, 3'b001, 3'b001, 32'h102,      32'h0,        32'h80010000, 1, 0, 4'b0000, 32'h0,        1, 1, 0, 32'hFFFF8001));
    vt.push_back(mk("lhu",    1, 0, 1, 0, 1, 3'b101, 3'b001, 32'h100,      32'h0,        32'h00008001, 1, 0, 4'b0000, 32'h0,        1, 1, 0, 32'h00008001));
`ifdef MEM_MISALIGN_TRAP_EN
    vt.push_back(mk("lw_mis", 1, 0, 1, 0, 1, 3'b010, 3'b001, 32'h101,      32'h0,        32'hDEADBEEF, 0, 0, 4'b0000, 32'h0,        1, 0, 1, 32'h0));
    vt.push_back(mk("lh_mis", 1, 0, 1, 0, 1, 3'b001, 3'b001, 32'h103,      32'h0,        32'h12345678, 0, 0, 4'b0000, 32'h0,        1, 0, 1, 32'h0));
`else
    vt.push_back(mk("lw_mis", 1, 0, 1, 0, 1, 3'b010, 3'b001, 32'h101,      32'h0,        32'hDEADBEEF, 1, 0, 4'b0000, 32'h0,        1, 1, 0, 32'hDEADBEEF));
    vt.push_back(mk("lh_mis", 1, 0, 1, 0, 1, 3'b001, 3'b001, 32'h103,      32'h0,        32'h12345678, 1, 0, 4'b0000, 32'h0,        1, 1, 0, 32'h00001234));
`endif
    vt.push_back(mk("rewe",   1, 0, 1, 1, 0, 3'b010, 3'b000, 32'h200,      32'h11223344, 32'hFFFFFFFF, 1, 1, 4'b1111, 32'h11223344, 1, 0, 0, 32'h0));
    vt.push_back(mk("flush",  1, 1, 1, 0, 1, 3'b010, 3'b001, 32'h300,      32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        0, 0, 0, 32'h0));
    vt.push_back(mk("novalid",0, 0, 1, 0, 1, 3'b010, 3'b001, 32'h304,      32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        0, 0, 0, 32'h0));
    vt.push_back(mk("lother", 1, 0, 1, 0, 1, 3'b111, 3'b001, 32'h104,      32'h0,        32'h87654321, 1, 0, 4'b0000, 32'h0,        1, 1, 0, 32'h87654321));
    vt.push_back(mk("lb_neg", 1, 0, 1, 0, 1, 3'b000, 3'b001, 32'h100,      32'h0,        32'h000000FF, 1, 0, 4'b0000, 32'h0,        1, 1, 0, 32'hFFFFFFFF));

    repeat (2) @(negedge clk);
    chk("rst:valid", valid_MEM, 1'b0);
    chk("rst:stall", stall_out, 1'b0);
    chk("rst:req", bus_req, 1'b0);
    chk("rst:alu", aluResult_MEM, 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      v = vt[i];
      @(negedge clk);
      valid_EXE = v.v; flush = v.fl; memRe_EXE = v.re; memWe_EXE = v.we;
      regFileWe_EXE = v.rfwe; funct3_EXE = v.f3; RFWDSrcMuxSel_EXE = v.sel;
      aluResult_EXE = v.alu; RFData2_EXE = v.rs2; bus_rdata = v.rdata; bus_ready = 1'b1;
      exp_side = {3{32'h5A5A0000 ^ 32'(i)}};
      side_EXE = exp_side;
      #1;
      chk({v.name, ":bus_req"}, bus_req, v.e_req);
      chk({v.name, ":stall"}, stall_out, 1'b0);
      if (v.e_req) begin
        chk({v.name, ":bus_we"}, bus_we, v.e_we);
        chk({v.name, ":bus_addr"}, bus_addr, v.alu);
        if (v.e_we) begin
          chk({v.name, ":bus_be"}, bus_be, v.e_be);
          chk({v.name, ":bus_wdata"}, bus_wdata, v.e_wdata);
        end
      end
      @(posedge clk); #1;
      chk({v.name, ":valid_MEM"}, valid_MEM, v.e_valid);
      if (v.e_valid) begin
        chk({v.name, ":rfwe_MEM"}, regFileWe_MEM, v.e_rfwe);
        chk({v.name, ":err_MEM"}, memErr_MEM, v.e_err);
        chk({v.name, ":rdata_MEM"}, busRData_MEM, v.e_rdata);
        chk({v.name, ":alu_MEM"}, aluResult_MEM, v.alu);
        chk({v.name, ":sel_MEM"}, RFWDSrcMuxSel_MEM, v.sel);
        chk({v.name, ":side_MEM"}, side_MEM, exp_side);
      end
    end

    // LB at 0x102 answered on the third WAIT cycle; flush and changed EXE fields mid-wait must not disturb it
    @(negedge clk);
    idle_inputs();
    valid_EXE = 1'b1; memRe_EXE = 1'b1; regFileWe_EXE = 1'b1; funct3_EXE = 3'b000;
    RFWDSrcMuxSel_EXE = 3'b001; aluResult_EXE = 32'h102; side_EXE = {3{32'hA0A00032}};
    #1;
    chk("lbw:req_issue", bus_req, 1'b1);
    chk("lbw:stall_issue", stall_out, 1'b0);
    @(posedge clk); #1;
    chk("lbw:valid_issue", valid_MEM, 1'b0);
    stalls = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      aluResult_EXE = 32'hFFF; funct3_EXE = 3'b010; side_EXE = '0;
      flush = (k == 2); bus_ready = (k == 3); bus_rdata = 32'h00800000;
      #1;
      if (stall_out) stalls++;
      chk("lbw:req_wait", bus_req, 1'b1);
      chk("lbw:addr_wait", bus_addr, 32'h102);
      @(posedge clk); #1;
      if (k < 3) chk("lbw:valid_wait", valid_MEM, 1'b0);
    end
    chk("lbw:stall_cycles", stalls, 3);
    chk("lbw:valid_done", valid_MEM, 1'b1);
    chk("lbw:rdata", busRData_MEM, 32'hFFFFFF80);
    chk("lbw:rfwe", regFileWe_MEM, 1'b1);
    chk("lbw:err", memErr_MEM, 1'b0);
    chk("lbw:alu", aluResult_MEM, 32'h102);
    chk("lbw:side", side_MEM, {3{32'hA0A00032}});
    chk("lbw:stall_done", stall_out, 1'b0);

    // LHU at 0x200 never answered: abort after four WAIT cycles
    @(negedge clk);
    idle_inputs();
    valid_EXE = 1'b1; memRe_EXE = 1'b1; regFileWe_EXE = 1'b1; funct3_EXE = 3'b101;
    aluResult_EXE = 32'h200;
    #1;
    chk("to:req_issue", bus_req, 1'b1);
    @(posedge clk); #1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      valid_EXE = 1'b0;
      #1;
      chk("to:req_wait", bus_req, 1'b1);
      chk("to:stall_wait", stall_out, 1'b1);
      @(posedge clk); #1;
      if (k < 4) chk("to:valid_wait", valid_MEM, 1'b0);
    end
    chk("to:valid", valid_MEM, 1'b1);
    chk("to:err", memErr_MEM, 1'b1);
    chk("to:rfwe", regFileWe_MEM, 1'b0);
    chk("to:req_drop", bus_req, 1'b0);
    chk("to:stall_drop", stall_out, 1'b0);
    chk("to:alu", aluResult_MEM, 32'h200);

    // Reset asserted mid-WAIT, then a flushed entry after release
    @(negedge clk);
    idle_inputs();
    valid_EXE = 1'b1; memRe_EXE = 1'b1; regFileWe_EXE = 1'b1; funct3_EXE = 3'b010;
    aluResult_EXE = 32'h300;
    @(posedge clk); #1;
    chk("rw:stall_pre", stall_out, 1'b1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rw:stall", stall_out, 1'b0);
    chk("rw:req", bus_req, 1'b0);
    chk("rw:valid", valid_MEM, 1'b0);
    chk("rw:err", memErr_MEM, 1'b0);
    chk("rw:alu", aluResult_MEM, 32'h0);
    chk("rw:rdata", busRData_MEM, 32'h0);
    chk("rw:side", side_MEM, 96'h0);
    @(negedge clk);
    reset_n = 1'b1;
    flush = 1'b1;
    #1;
    chk("rw:req_flush", bus_req, 1'b0);
    @(posedge clk); #1;
    chk("rw:valid_flush", valid_MEM, 1'b0);
    chk("rw:stall_flush", stall_out, 1'b0);

    @(negedge clk);
    idle_inputs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_hs.md
MEM_STAGE_HS -- requirements
Module: mem_stage_hs

Interface
REQ-001 SHALL provide parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 SHALL provide parameter ADDR_W, default 32, bus address width.
REQ-003 SHALL provide parameter SIDE_W, default 96, width of the opaque sideband bundle (instrCode/immExt/PC).
REQ-004 SHALL provide parameter TIMEOUT, default 255, maximum wait cycles before bus abort; legal range 1..65535.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 valid_EXE  in  1  EXE entry present.
REQ-008 regFileWe_EXE  in  1; RFWDSrcMuxSel_EXE  in  3  writeback controls.
REQ-009 memRe_EXE  in  1; memWe_EXE  in  1; funct3_EXE  in  3  access type.
REQ-010 aluResult_EXE  in  XLEN  address/result; RFData2_EXE  in  XLEN  store data.
REQ-011 side_EXE  in  SIDE_W  pass-through bundle.
REQ-012 flush  in  1  kill current EXE entry.
REQ-013 stall_out  out  1  upstream hold.
REQ-014 bus_req/bus_we  out  1; bus_addr  out  ADDR_W; bus_wdata  out  XLEN; bus_be  out  XLEN/8.
REQ-015 bus_ready  in  1; bus_rdata  in  XLEN.
REQ-016 valid_MEM, regFileWe_MEM, memErr_MEM  out  1; RFWDSrcMuxSel_MEM  out  3; aluResult_MEM, busRData_MEM  out  XLEN; side_MEM  out  SIDE_W.

Function
REQ-017 Entry SHALL be accepted when valid_EXE=1, flush=0, stall_out=0; flush=1 discards the EXE entry and yields valid_MEM=0 the next cycle.
REQ-018 Accepted non-access entry SHALL appear on all *_MEM outputs exactly one cycle later, with busRData_MEM=0.
REQ-019 FSM SHALL have states IDLE and WAIT; stall_out=1 exactly while in WAIT.
REQ-020 In IDLE, an accepted access SHALL drive bus_req=1 combinationally that cycle; bus_ready=1 the same cycle completes with one-cycle latency.
REQ-021 Otherwise, the request SHALL be captured, FSM enters WAIT, and bus_addr/bus_wdata/bus_be/bus_we held stable with bus_req=1 until bus_ready.
REQ-022 While in WAIT, valid_MEM SHALL be 0; on bus_ready, outputs SHALL be registered at that edge and FSM returns to IDLE.
REQ-023 Wait counter SHALL reset on WAIT entry; reaching TIMEOUT without bus_ready SHALL drop bus_req and emit valid_MEM=1, memErr_MEM=1, regFileWe_MEM=0, then return to IDLE.
REQ-024 flush during WAIT SHALL NOT abort the outstanding transaction.
REQ-025 Loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, 110 LWU and 011 LD (XLEN=64 only); lane selected by address low bits; signed forms sign-extend to XLEN; other codes behave as full-width load.
REQ-026 Stores: SB replicates byte across bus_wdata with one-hot bus_be at offset; SH replicates halfword, two-bit bus_be; SW/SD full-lane bus_be.
REQ-027 bus_addr SHALL be aluResult truncated to ADDR_W with no alignment masking; memRe and memWe both set SHALL be treated as store.

Reset
REQ-028 reset_n=0 SHALL immediately force state IDLE, counter 0, bus_req=0, stall_out=0 and every *_MEM output to 0, including mid-WAIT.

Configuration
REQ-029 With MEM_MISALIGN_TRAP_EN defined, halfword with odd address or word/double not naturally aligned SHALL issue no bus_req and emit, one cycle later, valid_MEM=1, memErr_MEM=1, regFileWe_MEM=0.
REQ-030 Without MEM_MISALIGN_TRAP_EN, address bits below access size SHALL be ignored for lane selection (access forced aligned) and memErr_MEM asserts only on timeout.

Verification
REQ-031 Store SB addr 0x103 data 0xA5, bus_ready=1 immediately -> bus_be=1000, bus_wdata=0xA5A5A5A5, no stall.
REQ-032 LB addr 0x102, bus_ready after 3 cycles, rdata 0x00800000 -> stall_out high 3 cycles, busRData_MEM=0xFFFFFF80.
REQ-033 LHU addr 0x200, bus_ready never, TIMEOUT=4 -> bus_req drops after 4 WAIT cycles, memErr_MEM=1, regFileWe_MEM=0.
REQ-034 LW addr 0x101 with macro -> no bus_req, memErr_MEM=1; without macro -> access at lane 0, memErr_MEM=0.
REQ-035 Assert reset_n=0 mid-WAIT, then load flush=1 with valid_EXE=1 -> all outputs 0 at once; flushed entry yields valid_MEM=0.
